mips32_mem_arbiter: RTL and testbench

- Shares the single unified instruction/data memory of the pipelined MIPS32 core between two requesters:
  - the IF-stage instruction fetch port;
  - the MEM-stage load/store port.
- Serialises accesses with a request/acknowledge handshake on each side.
- Gives data accesses priority, with a streak limit so fetches are not starved.
- Supports a halt that blocks new fetches, and a watchdog that aborts a memory access that never completes.

---
 rtl/mips32_mem_arbiter_if.sv | 40 ++++
 rtl/mips32_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mips32_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips32_mem_arbiter_if.sv
// Signal bundle between the MIPS32 fetch and load/store ports, the memory arbiter and the unified memory.
// The arbiter uses the slave view; the core/memory environment uses the master view.
interface mips32_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic          halt;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, halt, mem_ack, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, busy, err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, halt, mem_ack, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, busy, err
  );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// Arbiter sharing one unified memory between the IF fetch port and the MEM load/store port.
// Data has priority, bounded by a streak limit; a watchdog aborts accesses the memory never acks.
module mips32_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STREAK_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic               clk1,
  input  logic               rst_n,
  mips32_mem_arbiter_if.slave bus
);

  localparam int SW = $clog2(STREAK_MAX + 1);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STREAK_LIM = SW'(STREAK_MAX);
  localparam logic [WW-1:0] WDOG_LIM   = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [WW-1:0] wdog_q, wdog_d;

  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          i_ack_q, i_ack_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic          fetch_elig;
  logic          data_elig;

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    wdog_d      = wdog_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_ack_d     = 1'b0;
    d_rdata_d   = d_rdata_q;
    err_d       = 1'b0;

    // A port acked this cycle still shows its old request, so it must not be re-granted now.
    fetch_elig = bus.i_req & ~bus.halt & ~i_ack_q;
    data_elig  = bus.d_req & ~d_ack_q;

    case (state_q)
      IDLE: begin
        if (data_elig && !(fetch_elig && (streak_q == STREAK_LIM))) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          wdog_d      = '0;
          streak_d    = fetch_elig ? streak_q + SW'(1) : '0;
        end else if (fetch_elig) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.i_addr;
          mem_wdata_d = '0;
          wdog_d      = '0;
          streak_d    = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == BUSY_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = bus.mem_rdata;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = mem_we_q ? '0 : bus.mem_rdata;
          end
        end else if (wdog_q == WDOG_LIM) begin
          // Abort: the requester still gets its ack so the pipeline can move on, flagged by err.
          state_d   = IDLE;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (state_q == BUSY_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = '0;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = '0;
          end
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      wdog_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_ack_q     <= 1'b0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      wdog_q      <= wdog_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_ack_q     <= d_ack_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed bench for mips32_mem_arbiter: behavioural memory/responder process plus a main
// sequence of fetch, store/load, timeout, contention, streak, halt and async-reset scenarios.
module tb_mips32_mem_arbiter;
  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int STREAK_MAX = 4;
  localparam int TIMEOUT    = 8;

  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk1 = ~clk1;

  mips32_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mips32_mem_arbiter #(
    .AW(AW), .DW(DW), .STREAK_MAX(STREAK_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Written by the main sequence, read by the responder.
  logic halt_r      = 1'b0;
  logic streak_mode = 1'b0;
  logic mem_auto    = 1'b1;
  int   mem_lat     = 1;
  int   stray_cnt   = 0;

  // Written by the responder, read by the main sequence.
  int   n_grant = 0;
  int   n_iack  = 0;
  int   n_dack  = 0;
  int   n_err   = 0;
  logic alog[$];   // ack order: 1 = data, 0 = fetch

  logic [31:0] mem [0:255];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk1);
      #2;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic mwe, output logic [31:0] maddr, output logic [31:0] mwdata,
                          output logic ok, output logic e, output logic [31:0] rdata);
    int n;
    bus.d_we    = we;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    bus.d_req   = 1'b1;
    n = 0;
    while (!bus.mem_req && n < 20) begin
      step(1);
      n++;
    end
    mwe    = bus.mem_we;
    maddr  = bus.mem_addr;
    mwdata = bus.mem_wdata;
    n = 0;
    while (!bus.d_ack && n < 100) begin
      step(1);
      n++;
    end
    ok    = bus.d_ack;
    e     = bus.err;
    rdata = bus.d_rdata;
    bus.d_req = 1'b0;
    step(1);
  endtask

  // Memory responder: acks mem_req after mem_lat cycles, logs acks and grants, drives halt.
  initial begin
    int   age;
    int   stray_done;
    logic prev_req;
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
    mem[2]  = 32'h28020014;
    mem[17] = 32'h0BADC0DE;
    mem[64] = 32'h11110000;
    mem[65] = 32'h22220000;
    age = 0;
    stray_done = 0;
    prev_req = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'hDEADBEEF;
    bus.halt      = 1'b0;
    forever begin
      @(posedge clk1);
      #1;
      if (bus.i_ack) begin n_iack++; alog.push_back(1'b0); end
      if (bus.d_ack) begin n_dack++; alog.push_back(1'b1); end
      if (bus.err) n_err++;
      if (bus.mem_req && !prev_req) n_grant++;
      prev_req = bus.mem_req;
      bus.halt = halt_r | (streak_mode & bus.d_ack);
      if (bus.mem_req && mem_auto && age == mem_lat) begin
        bus.mem_ack = 1'b1;
        if (bus.mem_we) begin
          mem[bus.mem_addr[9:2]] = bus.mem_wdata;
          bus.mem_rdata = 32'hCAFEF00D;
        end else begin
          bus.mem_rdata = mem[bus.mem_addr[9:2]];
        end
      end else if (stray_cnt != stray_done) begin
        stray_done = stray_cnt;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h5A5A5A5A;
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'hDEADBEEF;
      end
      age = bus.mem_req ? age + 1 : 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic        mwe, ok, e;
    logic [31:0] maddr, mwdata, rdata;
    int          cnt, n, base_log, b_i, b_d, b_g, b_e;
    logic [10:0] pat;

    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;

    // Reset state
    #12;
    check_eq("rst_ctl", {bus.mem_req, bus.mem_we, bus.i_ack, bus.d_ack, bus.busy, bus.err}, 6'b0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
    check_eq("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check_eq("rst_rdata", {bus.i_rdata, bus.d_rdata}, 64'h0);
    step(1);
    rst_n = 1'b1;
    step(1);

    // Single fetch: request in cycle 0
    bus.i_addr = 32'h8;
    bus.i_req  = 1'b1;
    step(1);
    check_eq("fetch_c1_req", {bus.mem_req, bus.busy, bus.mem_we}, 3'b110);
    check_eq("fetch_c1_addr", bus.mem_addr, 32'h8);
    step(1);
    check_eq("fetch_c2_req_noack", {bus.mem_req, bus.i_ack}, 2'b10);
    step(1);
    check_eq("fetch_c3_ack", {bus.i_ack, bus.mem_req, bus.busy, bus.err}, 4'b1000);
    check_eq("fetch_c3_rdata", bus.i_rdata, 32'h28020014);
    bus.i_req = 1'b0;
    step(1);
    check_eq("fetch_c4_ack_pulse", bus.i_ack, 1'b0);

    // Store then load through the behavioural memory
    d_access(1'b1, 32'h40, 32'h19, mwe, maddr, mwdata, ok, e, rdata);
    check_eq("store_mem_we", mwe, 1'b1);
    check_eq("store_mem_addr", maddr, 32'h40);
    check_eq("store_mem_wdata", mwdata, 32'h19);
    check_eq("store_ack_err", {ok, e}, 2'b10);
    check_eq("store_rdata", rdata, 32'h0);
    d_access(1'b0, 32'h40, 32'h0, mwe, maddr, mwdata, ok, e, rdata);
    check_eq("load_mem_we", mwe, 1'b0);
    check_eq("load_ack_err", {ok, e}, 2'b10);
    check_eq("load_rdata", rdata, 32'h19);

    // mem_ack in the very cycle the watchdog expires counts as completion
    mem_lat = TIMEOUT - 1;
    d_access(1'b0, 32'h44, 32'h0, mwe, maddr, mwdata, ok, e, rdata);
    check_eq("edge_ack_err", {ok, e}, 2'b10);
    check_eq("edge_rdata", rdata, 32'h0BADC0DE);

    // Timeout: memory never acks a load
    mem_auto = 1'b0;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h48;
    bus.d_req  = 1'b1;
    step(1);
    cnt = 0;
    n = 0;
    while (bus.mem_req && n < 40) begin
      cnt++;
      step(1);
      n++;
    end
    check_eq("to_req_cycles", cnt, TIMEOUT);
    check_eq("to_ack_err_busy", {bus.d_ack, bus.err, bus.busy, bus.mem_req}, 4'b1100);
    check_eq("to_rdata", bus.d_rdata, 32'h0);
    bus.d_req = 1'b0;
    b_i = n_iack; b_d = n_dack; b_e = n_err;
    stray_cnt++;
    step(5);
    check_eq("stray_no_ack", (n_iack - b_i) + (n_dack - b_d) + (n_err - b_e), 0);
    check_eq("stray_idle", {bus.mem_req, bus.busy}, 2'b00);
    mem_auto = 1'b1;
    mem_lat  = 1;

    // Contention without a streak: the ack-cycle mask alternates the ports
    do_reset();
    base_log = alog.size();
    b_i = n_iack; b_d = n_dack; b_g = n_grant;
    bus.i_addr = 32'h100;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h80;
    bus.i_req  = 1'b1;
    bus.d_req  = 1'b1;
    step(40);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    step(10);
    check_eq("cont_len", (alog.size() - base_log) >= 10, 1'b1);
    pat = '0;
    for (int k = 0; k < 10; k++) pat[k] = alog[base_log + k];
    check_eq("cont_order", pat[9:0], 10'b0101010101);
    check_eq("cont_acks_eq_grants", (n_iack - b_i) + (n_dack - b_d), n_grant - b_g);
    check_eq("cont_i_rdata", bus.i_rdata, 32'h11110000);

    // Streak limit: halt pulsed with each d_ack keeps fetch out of the data ack cycles
    do_reset();
    streak_mode = 1'b1;
    base_log = alog.size();
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    step(60);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    step(10);
    streak_mode = 1'b0;
    check_eq("streak_len", (alog.size() - base_log) >= 11, 1'b1);
    pat = '0;
    for (int k = 0; k < 11; k++) pat[k] = alog[base_log + k];
    check_eq("streak_order", pat, 11'b01111101111);

    // Halt while a fetch is in flight
    do_reset();
    bus.i_addr = 32'h104;
    bus.i_req  = 1'b1;
    step(1);
    halt_r     = 1'b1;
    bus.d_addr = 32'h84;
    bus.d_req  = 1'b1;
    b_i = n_iack; b_d = n_dack;
    step(30);
    check_eq("halt_inflight_done", n_iack - b_i, 1);
    check_eq("halt_fetch_rdata", bus.i_rdata, 32'h22220000);
    check_eq("halt_data_served", (n_dack - b_d) >= 3, 1'b1);
    b_i = n_iack;
    halt_r = 1'b0;
    step(10);
    check_eq("halt_release_fetch", (n_iack - b_i) > 0, 1'b1);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    step(10);

    // Asynchronous reset in cycle 3 of a fetch
    do_reset();
    mem_lat    = 5;
    bus.i_addr = 32'h8;
    bus.i_req  = 1'b1;
    step(3);
    check_eq("arst_pre_req", bus.mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_immediate", {bus.mem_req, bus.busy}, 2'b00);
    bus.i_req = 1'b0;
    step(2);
    rst_n = 1'b1;
    b_i = n_iack;
    step(10);
    check_eq("arst_no_ack", n_iack - b_i, 0);
    mem_lat   = 1;
    bus.i_req = 1'b1;
    n = 0;
    while (!bus.i_ack && n < 20) begin
      step(1);
      n++;
    end
    check_eq("arst_next_ack", {bus.i_ack, bus.err}, 2'b10);
    check_eq("arst_next_rdata", bus.i_rdata, 32'h28020014);
    bus.i_req = 1'b0;
    step(3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
